// File: rtl/prime_count_core_if.sv
// Method-call handshake bundle for prime_count_core: field write ports,
// field read-back ports and the run_req/run_busy pair.
interface prime_count_core_if #(
  parameter int LIMIT_WIDTH  = 16,
  parameter int RESULT_WIDTH = 32
);
  logic [LIMIT_WIDTH-1:0]  limit_in;
  logic                    limit_we;
  logic [LIMIT_WIDTH-1:0]  limit_out;
  logic [RESULT_WIDTH-1:0] result_in;
  logic                    result_we;
  logic [RESULT_WIDTH-1:0] result_out;
  logic                    finish_flag_in;
  logic                    finish_flag_we;
  logic                    finish_flag_out;
  logic                    run_req;
  logic                    run_busy;

  // Initiator side: drives writes and requests, observes fields.
  modport master (
    output limit_in, limit_we, result_in, result_we,
           finish_flag_in, finish_flag_we, run_req,
    input  limit_out, result_out, finish_flag_out, run_busy
  );

  // Callee side: the core that owns the fields and the run method.
  modport slave (
    input  limit_in, limit_we, result_in, result_we,
           finish_flag_in, finish_flag_we, run_req,
    output limit_out, result_out, finish_flag_out, run_busy
  );
endinterface

// File: rtl/prime_count_core.sv
// Callee for the `run` method: counts primes in [2, limit) by trial
// division, with the modulo done by repeated subtraction.
module prime_count_core #(
  parameter int LIMIT_WIDTH  = 16,
  parameter int RESULT_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  prime_count_core_if.slave   bus
);

  localparam int NW = LIMIT_WIDTH + 1;      // n, d, r: n may reach 2^LIMIT_WIDTH
  localparam int DW = 2 * LIMIT_WIDTH + 2;  // dsq never overflows

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    CHECK_N,
    CHECK_D,
    MOD,
    DONE
  } state_t;

  state_t                  state_q;
  logic [LIMIT_WIDTH-1:0]  limit_q;
  logic [RESULT_WIDTH-1:0] result_q;
  logic                    finish_q;
  logic                    busy_q;
  logic [NW-1:0]           n_q;
  logic [NW-1:0]           d_q;
  logic [NW-1:0]           r_q;
  logic [DW-1:0]           dsq_q;
  logic [RESULT_WIDTH-1:0] count_q;

  logic [DW-1:0]           dsq_d;
  logic [NW-1:0]           r_d;

  // Next divisor square (d+1)^2 = d^2 + 2d + 1 and one subtraction step.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path; a missed
    // branch would otherwise infer a latch.
    dsq_d = dsq_q + (DW'(d_q) << 1) + DW'(1);
    r_d   = r_q - d_q;
  end

  // Field registers and the run FSM, all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      limit_q  <= '0;
      result_q <= '0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
      n_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      dsq_q    <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before this edge.
      case (state_q)
        IDLE: begin
          if (bus.limit_we)       limit_q  <= bus.limit_in;
          if (bus.result_we)      result_q <= bus.result_in;
          if (bus.finish_flag_we) finish_q <= bus.finish_flag_in;
          // Starting a run clears the flag even if it was written this cycle.
          if (bus.run_req) begin
            state_q  <= INIT;
            busy_q   <= 1'b1;
            finish_q <= 1'b0;
          end
        end
        INIT: begin
          n_q     <= NW'(2);
          count_q <= '0;
          state_q <= CHECK_N;
        end
        CHECK_N: begin
          if (n_q >= NW'(limit_q)) begin
            state_q <= DONE;
          end else begin
            d_q     <= NW'(2);
            dsq_q   <= DW'(4);
            state_q <= CHECK_D;
          end
        end
        CHECK_D: begin
          if (dsq_q > DW'(n_q)) begin
            count_q <= count_q + RESULT_WIDTH'(1);
            n_q     <= n_q + NW'(1);
            state_q <= CHECK_N;
          end else begin
            r_q     <= n_q;
            state_q <= MOD;
          end
        end
        MOD: begin
          if (r_q >= d_q) begin
            r_q <= r_d;
          end else if (r_q == '0) begin
            n_q     <= n_q + NW'(1);
            state_q <= CHECK_N;
          end else begin
            d_q     <= d_q + NW'(1);
            dsq_q   <= dsq_d;
            state_q <= CHECK_D;
          end
        end
        DONE: begin
          result_q <= count_q;
          finish_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.limit_out       = limit_q;
  assign bus.result_out      = result_q;
  assign bus.finish_flag_out = finish_q;
  assign bus.run_busy        = busy_q;

endmodule

// File: tb/tb_prime_count_core.sv
// Directed bench for prime_count_core: reset state, field writes, several
// prime counts, busy protection, asynchronous reset mid-run, back-to-back.
module tb_prime_count_core;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  prime_count_core_if #(.LIMIT_WIDTH(16), .RESULT_WIDTH(32)) bus_if ();

  prime_count_core #(.LIMIT_WIDTH(16), .RESULT_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, reports tag/observed/expected on mismatch.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write limit and request run in the same cycle (edge E0).
  task automatic start_run(input logic [15:0] lim);
    bus_if.limit_in = lim;
    bus_if.limit_we = 1'b1;
    bus_if.run_req  = 1'b1;
    tick();
    bus_if.limit_we = 1'b0;
    bus_if.run_req  = 1'b0;
  endtask

  // Wait for run_busy to fall; busy_cyc counts cycles with run_busy high,
  // including the one after E0. Flags a finish seen while still busy.
  task automatic wait_done(input int budget, output int busy_cyc,
                           output logic timed_out, output logic early_finish);
    busy_cyc     = 1;
    timed_out    = 1'b1;
    early_finish = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!bus_if.run_busy) begin
        timed_out = 1'b0;
        break;
      end
      if (bus_if.finish_flag_out) early_finish = 1'b1;
      busy_cyc++;
    end
  endtask

  initial begin
    int   cyc;
    logic to;
    logic early;

    total  = 0;
    passed = 0;
    bus_if.limit_in       = '0;
    bus_if.limit_we       = 1'b0;
    bus_if.result_in      = '0;
    bus_if.result_we      = 1'b0;
    bus_if.finish_flag_in = 1'b0;
    bus_if.finish_flag_we = 1'b0;
    bus_if.run_req        = 1'b0;

    // Reset held for 3 cycles.
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_limit",  32'(bus_if.limit_out), 32'd0);
    check("rst_result", bus_if.result_out, 32'd0);
    check("rst_finish", 32'(bus_if.finish_flag_out), 32'd0);
    check("rst_busy",   32'(bus_if.run_busy), 32'd0);

    // Field write in IDLE.
    bus_if.limit_in = 16'd10;
    bus_if.limit_we = 1'b1;
    tick();
    bus_if.limit_we = 1'b0;
    check("wr_limit", 32'(bus_if.limit_out), 32'd10);

    // limit=10 via run_req pulse alone: primes 2,3,5,7.
    bus_if.run_req = 1'b1;
    tick();
    bus_if.run_req = 1'b0;
    check("l10_busy_rise", 32'(bus_if.run_busy), 32'd1);
    check("l10_finish_low", 32'(bus_if.finish_flag_out), 32'd0);
    wait_done(5000, cyc, to, early);
    check("l10_timeout", 32'(to), 32'd0);
    check("l10_early_finish", 32'(early), 32'd0);
    check("l10_result", bus_if.result_out, 32'd4);
    check("l10_finish", 32'(bus_if.finish_flag_out), 32'd1);

    // A write of finish_flag=0 and of result in IDLE.
    bus_if.finish_flag_in = 1'b0;
    bus_if.finish_flag_we = 1'b1;
    bus_if.result_in      = 32'd77;
    bus_if.result_we      = 1'b1;
    tick();
    bus_if.finish_flag_we = 1'b0;
    bus_if.result_we      = 1'b0;
    check("wr_finish_clear", 32'(bus_if.finish_flag_out), 32'd0);
    check("wr_result", bus_if.result_out, 32'd77);

    // Minimum runs: limit=2 and limit=0, busy exactly 3 cycles.
    start_run(16'd2);
    wait_done(100, cyc, to, early);
    check("l2_timeout", 32'(to), 32'd0);
    check("l2_busy_cycles", 32'(cyc), 32'd3);
    check("l2_result", bus_if.result_out, 32'd0);
    check("l2_finish", 32'(bus_if.finish_flag_out), 32'd1);

    start_run(16'd0);
    wait_done(100, cyc, to, early);
    check("l0_busy_cycles", 32'(cyc), 32'd3);
    check("l0_result", bus_if.result_out, 32'd0);

    start_run(16'd3);
    wait_done(100, cyc, to, early);
    check("l3_timeout", 32'(to), 32'd0);
    check("l3_result", bus_if.result_out, 32'd1);

    // limit=100 with busy protection: all writes and run_req ignored.
    start_run(16'd100);
    repeat (10) tick();
    bus_if.run_req   = 1'b1;
    bus_if.limit_in  = 16'd5;
    bus_if.limit_we  = 1'b1;
    bus_if.result_in = 32'd7;
    bus_if.result_we = 1'b1;
    tick();
    bus_if.run_req   = 1'b0;
    bus_if.limit_we  = 1'b0;
    bus_if.result_we = 1'b0;
    check("l100_busy_held", 32'(bus_if.run_busy), 32'd1);
    check("l100_limit_kept", 32'(bus_if.limit_out), 32'd100);
    wait_done(20000, cyc, to, early);
    check("l100_timeout", 32'(to), 32'd0);
    check("l100_result", bus_if.result_out, 32'd25);
    check("l100_limit_final", 32'(bus_if.limit_out), 32'd100);
    check("l100_finish", 32'(bus_if.finish_flag_out), 32'd1);
    // The ignored run_req must not have queued a second run.
    tick();
    check("l100_no_queue", 32'(bus_if.run_busy), 32'd0);

    // Asynchronous reset 50 cycles into a limit=1000 run.
    start_run(16'd1000);
    repeat (50) tick();
    check("l1000_busy", 32'(bus_if.run_busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_busy",   32'(bus_if.run_busy), 32'd0);
    check("mid_rst_limit",  32'(bus_if.limit_out), 32'd0);
    check("mid_rst_result", bus_if.result_out, 32'd0);
    check("mid_rst_finish", 32'(bus_if.finish_flag_out), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    start_run(16'd20);
    wait_done(5000, cyc, to, early);
    check("l20_timeout", 32'(to), 32'd0);
    check("l20_result", bus_if.result_out, 32'd8);

    // Back-to-back: new request the first cycle after run_busy falls.
    start_run(16'd30);
    check("b2b_finish_drop", 32'(bus_if.finish_flag_out), 32'd0);
    check("b2b_busy", 32'(bus_if.run_busy), 32'd1);
    wait_done(5000, cyc, to, early);
    check("b2b_timeout", 32'(to), 32'd0);
    check("b2b_early_finish", 32'(early), 32'd0);
    check("b2b_result", bus_if.result_out, 32'd10);
    check("b2b_finish", 32'(bus_if.finish_flag_out), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prime_count_core.md
# prime_count_core

Callee-side implementation of the method-call handshake used by our generated simulation modules. The block owns one method, `run`, which counts the primes in [2, limit) using trial division by repeated subtraction. It publishes the count on `result_out` and raises `finish_flag_out`. A bench top or a parent controller drives it through field ports (`*_in` / `*_we` / `*_out`) and a `run_req` / `run_busy` pair, exactly as an initiator drives any generated module.

## Interface
- LIMIT_WIDTH, 16: width of the `limit` field (unsigned).
- RESULT_WIDTH, 32: width of the `result` field (unsigned count).
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low; reset is asserted while `reset`=0.
- limit_in  input  LIMIT_WIDTH  write data for `limit`.
- limit_we  input  1  write strobe for `limit`.
- limit_out  output  LIMIT_WIDTH  current `limit`.
- result_in  input  RESULT_WIDTH  write data for `result`.
- result_we  input  1  write strobe for `result`.
- result_out  output  RESULT_WIDTH  current `result`.
- finish_flag_in  input  1  write data for `finish_flag`.
- finish_flag_we  input  1  write strobe for `finish_flag`.
- finish_flag_out  output  1  current `finish_flag`.
- run_req  input  1  request to start `run`.
- run_busy  output  1  `run` in progress.

## Operation
- Reset values: limit_out=0, result_out=0, finish_flag_out=0, run_busy=0, FSM=IDLE. Internal n, d, dsq, r and count are cleared.
- Field writes: a write through `*_we` takes effect at the next edge, and only while the FSM is IDLE. While busy, all `*_we` inputs are ignored because the core owns the fields.
- Start: in IDLE with run_req=1 the FSM goes to INIT, run_busy becomes 1 and finish_flag_out becomes 0. If run_req and `*_we` are both high in that cycle, the write is applied and `run` uses the new `limit`. run_req while busy is ignored; there is no queuing.
- FSM states and transitions:
  - INIT: n=2, count=0 -> CHECK_N.
  - CHECK_N: if n >= limit -> DONE; else d=2, dsq=4 -> CHECK_D.
  - CHECK_D: if dsq > n, n is prime: count+1, n+1 -> CHECK_N. Otherwise r=n -> MOD.
  - MOD: if r >= d, r = r - d and stay in MOD. Otherwise:
    - if r = 0, n is composite: n+1 -> CHECK_N;
    - if r != 0: d+1, dsq = dsq + 2d + 1 (using the old d) -> CHECK_D.
  - DONE: result_out=count, finish_flag_out=1, run_busy=0 -> IDLE.
- Arithmetic:
  - All values are unsigned.
  - n, d and r are LIMIT_WIDTH+1 bits, so n = 2^LIMIT_WIDTH - 1 + 1 does not wrap.
  - dsq is 2*LIMIT_WIDTH+2 bits and never overflows.
  - count is RESULT_WIDTH bits and wraps modulo 2^RESULT_WIDTH (unreachable with the defaults).
- Boundaries:
  - limit=0, 1 or 2 yields result 0.
  - limit is latched at INIT, so it cannot change mid-run.
- Reset mid-run: all outputs return to their reset values immediately (asynchronously). No partial result is published.

## Timing
- run_busy rises at the edge that samples run_req and falls at the edge leaving DONE.
- result_out and finish_flag_out update at that same edge, so finish_flag_out=1 and the valid result appear together.
- Minimum run (limit <= 2):
  - E0 samples run_req -> INIT;
  - E1 -> CHECK_N;
  - E2 -> DONE;
  - E3 -> IDLE with finish=1.
  - run_busy is high for exactly 3 cycles.
- finish_flag_out stays 1 until the next run starts, a write clears it, or reset.
- A new run_req is accepted the first cycle after run_busy returns to 0.
- Latency is data-dependent. Each prime n costs 2 cycles, plus, for each trial divisor d, 1 cycle for CHECK_D and (floor(n/d)+1) cycles in MOD. There is no bound beyond the algorithm.

## Test plan
- Reset state: hold reset=0 for 3 cycles, then release -> every output is 0 and run_busy=0. Write limit=10 with limit_we -> limit_out=10 one edge later.
- limit=10, pulse run_req for 1 cycle -> run_busy rises next edge; at completion result_out=4, finish_flag_out=1 and run_busy=0 on the same edge.
- limit=2 and limit=0 -> result_out=0 with run_busy high exactly 3 cycles; limit=3 -> result_out=1; limit=100 -> result_out=25.
- Busy protection: during a limit=100 run, pulse run_req and write limit_we=1 with limit_in=5, and result_we with result_in=7 -> all ignored; result_out=25 and limit_out=100 at finish.
- Reset mid-run: start limit=1000 and assert reset 50 cycles in -> outputs 0 immediately. After release with limit=20 and a run -> result_out=8.
- Back-to-back: a second run_req the cycle after run_busy falls is accepted; finish_flag_out drops to 0 at that edge and rises again with the new result.
